// File: rtl/vga_reg_responder.sv
// AXI4-Lite register responder for the VGA mode registers.
// Writes land in shadow registers; a CTRL write moves the whole shadow set
// into the active timing outputs, either at once (display off) or at the
// next frame_end pulse (display on), so the timing generator never sees a
// partially programmed mode.
module vga_reg_responder #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   s_awaddr,
  input  logic                s_awvalid,
  output logic                s_awready,
  input  logic [DATA_W-1:0]   s_wdata,
  input  logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_wvalid,
  output logic                s_wready,
  output logic [1:0]          s_bresp,
  output logic                s_bvalid,
  input  logic                s_bready,
  input  logic [ADDR_W-1:0]   s_araddr,
  input  logic                s_arvalid,
  output logic                s_arready,
  output logic [DATA_W-1:0]   s_rdata,
  output logic [1:0]          s_rresp,
  output logic                s_rvalid,
  input  logic                s_rready,
  input  logic                frame_end,
  output logic [11:0]         horiz_display_start,
  output logic [11:0]         horiz_display_width,
  output logic [11:0]         horiz_sync_width,
  output logic [11:0]         horiz_total_width,
  output logic [11:0]         vert_display_start,
  output logic [11:0]         vert_display_width,
  output logic [11:0]         vert_sync_width,
  output logic [11:0]         vert_total_width,
  output logic                hpol,
  output logic                vpol,
  output logic [31:0]         fb_base,
  output logic [12:0]         pitch,
  output logic                display_en,
  output logic                update_pending
);

  if (DATA_W != 32) begin : g_bad_data_w
    $error("vga_reg_responder: DATA_W must be 32");
  end

  // Slots 0..6 are shadow words, slot 7 is CTRL.
  localparam logic [2:0] SLOT_CTRL = 3'd7;

  typedef enum logic {S_IDLE, S_PENDING} state_t;

  // Word index -> {mapped, slot}.
  function automatic logic [3:0] decode_addr(input logic [ADDR_W-3:0] idx);
    decode_addr = 4'b0000;
    if (idx < (ADDR_W-2)'(5))         decode_addr = {1'b1, idx[2:0]};
    else if (idx == (ADDR_W-2)'(64))  decode_addr = 4'b1101;
    else if (idx == (ADDR_W-2)'(65))  decode_addr = 4'b1110;
    else if (idx == (ADDR_W-2)'(66))  decode_addr = 4'b1111;
  endfunction

  // Implemented bits of each shadow word; everything else reads as zero.
  function automatic logic [31:0] field_mask(input logic [2:0] slot);
    case (slot)
      3'd0, 3'd1, 3'd2, 3'd3: field_mask = 32'h0FFF_0FFF;
      3'd4:                   field_mask = 32'h0000_0003;
      3'd5:                   field_mask = 32'hFFFF_FFFF;
      3'd6:                   field_mask = 32'h0000_1FFF;
      default:                field_mask = 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb,
                                              input logic [31:0] mask);
    logic [31:0] be;
    be = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    merge_bytes = ((old_v & ~be) | (new_v & be)) & mask;
  endfunction

  logic              r_rdy_en;
  logic              r_aw_full;
  logic              r_w_full;
  logic              r_bvalid;
  logic [1:0]        r_bresp;
  logic [ADDR_W-1:0] r_aw_addr;
  logic [31:0]       r_w_data;
  logic [3:0]        r_w_strb;
  logic              r_rvalid;
  logic [1:0]        r_rresp;
  logic [31:0]       r_rdata;
  logic [31:0]       r_sh  [7];
  logic [31:0]       r_act [7];
  state_t            r_state;
  logic              r_disp_en;
  logic              r_en_sh;

  logic              w_aw_hs;
  logic              w_w_hs;
  logic              w_ar_hs;
  logic              w_fire;
  logic [ADDR_W-1:0] w_awaddr;
  logic [31:0]       w_wdata;
  logic [3:0]        w_wstrb;
  logic [3:0]        w_wdec;
  logic [3:0]        w_rdec;
  logic              w_ctrl_wr;
  logic              w_frame_load;
  logic              w_en_after;
  logic [31:0]       w_rd_val;
  logic              w_unused;

  assign s_awready = r_rdy_en & ~r_aw_full & ~r_bvalid;
  assign s_wready  = r_rdy_en & ~r_w_full & ~r_bvalid;
  assign s_arready = r_rdy_en & ~r_rvalid;
  assign s_bvalid  = r_bvalid;
  assign s_bresp   = r_bresp;
  assign s_rvalid  = r_rvalid;
  assign s_rresp   = r_rresp;
  assign s_rdata   = r_rdata;

  assign w_aw_hs = s_awvalid & s_awready;
  assign w_w_hs  = s_wvalid & s_wready;
  assign w_ar_hs = s_arvalid & s_arready;

  // A beat arriving this cycle is used directly so the response can come
  // one cycle after the last handshake.
  assign w_awaddr = r_aw_full ? r_aw_addr : s_awaddr;
  assign w_wdata  = r_w_full ? r_w_data : s_wdata;
  assign w_wstrb  = r_w_full ? r_w_strb : s_wstrb;
  assign w_fire   = (r_aw_full | w_aw_hs) & (r_w_full | w_w_hs);
  assign w_wdec   = decode_addr(w_awaddr[ADDR_W-1:2]);
  assign w_rdec   = decode_addr(s_araddr[ADDR_W-1:2]);

  assign w_ctrl_wr    = w_fire & w_wdec[3] & (w_wdec[2:0] == SLOT_CTRL) & w_wstrb[0];
  assign w_frame_load = frame_end & (r_state == S_PENDING);
  // Display enable as seen after a coincident frame_end has been applied.
  assign w_en_after   = w_frame_load ? r_en_sh : r_disp_en;

  // Write channel handshake, holding-register occupancy and B response
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdy_en  <= 1'b0;
      r_aw_full <= 1'b0;
      r_w_full  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= 2'b00;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_fire) begin
        r_aw_full <= 1'b0;
        r_w_full  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= w_wdec[3] ? 2'b00 : 2'b10;
      end else begin
        if (w_aw_hs) r_aw_full <= 1'b1;
        if (w_w_hs)  r_w_full  <= 1'b1;
        if (r_bvalid && s_bready) r_bvalid <= 1'b0;
      end
    end
  end

  // Holding-register payload capture
  always_ff @(posedge clk) begin
    if (w_aw_hs) r_aw_addr <= s_awaddr;
    if (w_w_hs) begin
      r_w_data <= s_wdata;
      r_w_strb <= s_wstrb;
    end
  end

  // Shadow register writes with per-byte strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 7; i++) r_sh[i] <= '0;
    end else if (w_fire && w_wdec[3] && (w_wdec[2:0] != SLOT_CTRL)) begin
      r_sh[w_wdec[2:0]] <= merge_bytes(r_sh[w_wdec[2:0]], w_wdata, w_wstrb,
                                       field_mask(w_wdec[2:0]));
    end
  end

  // Update FSM: frame_end load is applied first, then a same-cycle CTRL write
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_disp_en <= 1'b0;
      r_en_sh   <= 1'b0;
      for (int i = 0; i < 7; i++) r_act[i] <= '0;
    end else begin
      if (w_frame_load) begin
        for (int i = 0; i < 7; i++) r_act[i] <= r_sh[i];
        r_disp_en <= r_en_sh;
        r_state   <= S_IDLE;
      end
      if (w_ctrl_wr) begin
        if (w_wdata[0]) begin
          r_en_sh <= 1'b1;
          if (!w_en_after) begin
            for (int i = 0; i < 7; i++) r_act[i] <= r_sh[i];
            r_disp_en <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            r_state <= S_PENDING;
          end
        end else begin
          r_en_sh   <= 1'b0;
          r_disp_en <= 1'b0;
          r_state   <= S_IDLE;
        end
      end
    end
  end

  // Readback mux: shadow words, or live status for CTRL
  always_comb begin
    w_rd_val = '0;
    if (w_rdec[3]) begin
      if (w_rdec[2:0] == SLOT_CTRL) w_rd_val = {30'b0, r_state == S_PENDING, r_disp_en};
      else                          w_rd_val = r_sh[w_rdec[2:0]];
    end
  end

  // Read channel: data registered on AR handshake, held until accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rvalid <= 1'b0;
      r_rresp  <= 2'b00;
      r_rdata  <= '0;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rresp  <= w_rdec[3] ? 2'b00 : 2'b10;
      r_rdata  <= w_rd_val;
    end else if (r_rvalid && s_rready) begin
      r_rvalid <= 1'b0;
    end
  end

  assign horiz_display_start = r_act[0][11:0];
  assign horiz_display_width = r_act[0][27:16];
  assign horiz_sync_width    = r_act[1][11:0];
  assign horiz_total_width   = r_act[1][27:16];
  assign vert_display_start  = r_act[2][11:0];
  assign vert_display_width  = r_act[2][27:16];
  assign vert_sync_width     = r_act[3][11:0];
  assign vert_total_width    = r_act[3][27:16];
  assign hpol                = r_act[4][1];
  assign vpol                = r_act[4][0];
  assign fb_base             = r_act[5];
  assign pitch               = r_act[6][12:0];
  assign display_en          = r_disp_en;
  assign update_pending      = (r_state == S_PENDING);

  assign w_unused = ^{w_awaddr[1:0], s_araddr[1:0],
                      r_act[0][31:28], r_act[0][15:12], r_act[1][31:28], r_act[1][15:12],
                      r_act[2][31:28], r_act[2][15:12], r_act[3][31:28], r_act[3][15:12],
                      r_act[4][31:2], r_act[6][31:13]};

endmodule

// File: tb/tb_vga_reg_responder.sv
// Self-checking bench for vga_reg_responder: transaction-level reference
// model compared against every output each cycle, plus directed literals.
module tb_vga_reg_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] s_awaddr = '0;
  logic        s_awvalid = 1'b0;
  logic        s_awready;
  logic [31:0] s_wdata = '0;
  logic [3:0]  s_wstrb = '0;
  logic        s_wvalid = 1'b0;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready = 1'b0;
  logic [11:0] s_araddr = '0;
  logic        s_arvalid = 1'b0;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready = 1'b0;
  logic        frame_end = 1'b0;
  logic [11:0] horiz_display_start, horiz_display_width, horiz_sync_width, horiz_total_width;
  logic [11:0] vert_display_start, vert_display_width, vert_sync_width, vert_total_width;
  logic        hpol, vpol;
  logic [31:0] fb_base;
  logic [12:0] pitch;
  logic        display_en, update_pending;

  vga_reg_responder #(.ADDR_W(12), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .frame_end(frame_end),
    .horiz_display_start(horiz_display_start), .horiz_display_width(horiz_display_width),
    .horiz_sync_width(horiz_sync_width), .horiz_total_width(horiz_total_width),
    .vert_display_start(vert_display_start), .vert_display_width(vert_display_width),
    .vert_sync_width(vert_sync_width), .vert_total_width(vert_total_width),
    .hpol(hpol), .vpol(vpol), .fb_base(fb_base), .pitch(pitch),
    .display_en(display_en), .update_pending(update_pending)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;
  bit fe_rand = 1'b0;
  bit fe_manual = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model (register map by byte address) -------
  localparam int CTRL_A = 'h108;
  logic [31:0] m_sh  [int];
  logic [31:0] m_act [int];
  bit          m_en, m_pend, m_rdy, m_bval, m_rval;
  logic [1:0]  m_bresp, m_rresp;
  logic [31:0] m_rdata;
  logic [11:0] m_awq [$];
  logic [35:0] m_wq  [$];

  function automatic bit m_mapped(input int wa);
    return wa inside {'h000, 'h004, 'h008, 'h00C, 'h010, 'h100, 'h104, CTRL_A};
  endfunction

  function automatic logic [31:0] m_mask(input int wa);
    case (wa)
      'h000, 'h004, 'h008, 'h00C: return 32'h0FFF0FFF;
      'h010: return 32'h3;
      'h100: return 32'hFFFFFFFF;
      'h104: return 32'h1FFF;
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_reset();
    int keys[7] = '{'h000, 'h004, 'h008, 'h00C, 'h010, 'h100, 'h104};
    foreach (keys[k]) begin
      m_sh[keys[k]] = '0;
      m_act[keys[k]] = '0;
    end
    m_en = 0; m_pend = 0; m_rdy = 0; m_bval = 0; m_rval = 0;
    m_bresp = 0; m_rresp = 0; m_rdata = 0;
    m_awq.delete(); m_wq.delete();
  endtask

  task automatic m_write(input logic [11:0] a, input logic [35:0] beat);
    int wa;
    logic [31:0] d, v;
    logic [3:0] st;
    wa = int'(a) & 'hFFC;
    d = beat[31:0];
    st = beat[35:32];
    if (!m_mapped(wa)) begin
      m_bresp = 2'b10;
      return;
    end
    m_bresp = 2'b00;
    if (wa == CTRL_A) begin
      if (st[0]) begin
        if (d[0]) begin
          if (!m_en) begin
            m_act = m_sh;
            m_en = 1;
            m_pend = 0;
          end else begin
            m_pend = 1;
          end
        end else begin
          m_en = 0;
          m_pend = 0;
        end
      end
    end else begin
      v = m_sh[wa];
      for (int b = 0; b < 4; b++) if (st[b]) v[8*b +: 8] = d[8*b +: 8];
      m_sh[wa] = v & m_mask(wa);
    end
  endtask

  // One clock edge of the model: read sees pre-edge state, frame_end
  // loads the pre-write shadow, then the write takes effect.
  task automatic model_step();
    bit aw_rdy, w_rdy, ar_rdy;
    int wa;
    aw_rdy = m_rdy && (m_awq.size() == 0) && !m_bval;
    w_rdy  = m_rdy && (m_wq.size() == 0) && !m_bval;
    ar_rdy = m_rdy && !m_rval;
    if (reset) begin
      m_reset();
      return;
    end
    if (s_arvalid && ar_rdy) begin
      m_rval = 1;
      wa = int'(s_araddr) & 'hFFC;
      if (!m_mapped(wa)) begin
        m_rresp = 2'b10; m_rdata = 0;
      end else begin
        m_rresp = 2'b00;
        m_rdata = (wa == CTRL_A) ? {30'b0, m_pend, m_en} : m_sh[wa];
      end
    end else if (m_rval && s_rready) begin
      m_rval = 0;
    end
    if (frame_end && m_pend) begin
      m_act = m_sh;
      m_en = 1;
      m_pend = 0;
    end
    if (s_awvalid && aw_rdy) m_awq.push_back(s_awaddr);
    if (s_wvalid && w_rdy)   m_wq.push_back({s_wstrb, s_wdata});
    if (m_bval && s_bready) m_bval = 0;
    if (m_awq.size() > 0 && m_wq.size() > 0) begin
      m_bval = 1;
      m_write(m_awq.pop_front(), m_wq.pop_front());
    end
    m_rdy = 1;
  endtask

  always @(posedge clk) model_step();

  task automatic compare_all();
    chk("awready", s_awready, m_rdy && m_awq.size() == 0 && !m_bval);
    chk("wready",  s_wready,  m_rdy && m_wq.size() == 0 && !m_bval);
    chk("arready", s_arready, m_rdy && !m_rval);
    chk("bvalid",  s_bvalid,  m_bval);
    chk("bresp",   s_bresp,   m_bresp);
    chk("rvalid",  s_rvalid,  m_rval);
    chk("rresp",   s_rresp,   m_rresp);
    chk("rdata",   s_rdata,   m_rdata);
    chk("h_start", horiz_display_start, m_act['h000][11:0]);
    chk("h_width", horiz_display_width, m_act['h000][27:16]);
    chk("h_sync",  horiz_sync_width,    m_act['h004][11:0]);
    chk("h_total", horiz_total_width,   m_act['h004][27:16]);
    chk("v_start", vert_display_start,  m_act['h008][11:0]);
    chk("v_width", vert_display_width,  m_act['h008][27:16]);
    chk("v_sync",  vert_sync_width,     m_act['h00C][11:0]);
    chk("v_total", vert_total_width,    m_act['h00C][27:16]);
    chk("hpol",    hpol,    m_act['h010][1]);
    chk("vpol",    vpol,    m_act['h010][0]);
    chk("fb_base", fb_base, m_act['h100]);
    chk("pitch",   pitch,   m_act['h104][12:0]);
    chk("display_en", display_en, m_en);
    chk("update_pending", update_pending, m_pend);
  endtask

  always @(negedge clk) if (chk_en) compare_all();

  // frame_end driver: random pulses or a directed level
  initial begin
    forever begin
      @(posedge clk);
      #1;
      frame_end = fe_rand ? ($urandom_range(0, 7) == 0) : fe_manual;
    end
  end

  // ---------------- bus tasks (start and end just after a rising edge) ----
  task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] st,
                           input int awd, input int wd, input int bd,
                           output logic [1:0] resp, output int lat, output int hi,
                           output logic aw_seen);
    int cyc = 0;
    bit aw_done = 0, w_done = 0, done = 0;
    logic aw_hs, w_hs;
    resp = 2'b11; lat = 0; hi = 0; aw_seen = 0;
    s_awaddr = a; s_wdata = d; s_wstrb = st;
    while (!(aw_done && w_done) && cyc < 40) begin
      s_awvalid = !aw_done && (cyc >= awd);
      s_wvalid  = !w_done && (cyc >= wd);
      @(negedge clk);
      aw_hs = s_awvalid && s_awready;
      w_hs  = s_wvalid && s_wready;
      @(posedge clk); #1;
      aw_done |= aw_hs;
      w_done  |= w_hs;
      cyc++;
    end
    s_awvalid = 0; s_wvalid = 0;
    chk("wr_addr_data_accepted", aw_done && w_done, 1);
    cyc = 0;
    while (!done && cyc < 40) begin
      s_bready = (hi >= bd);
      @(negedge clk);
      if (s_bvalid) begin
        if (hi == 0) lat = cyc + 1;
        resp = s_bresp;
        aw_seen |= s_awready;
        hi++;
        if (s_bready) done = 1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    s_bready = 0;
    chk("wr_b_response_seen", done, 1);
  endtask

  task automatic axi_read(input logic [11:0] a, output logic [31:0] data, output logic [1:0] resp);
    int cyc = 0;
    bit hs = 0, got = 0;
    data = 'x; resp = 2'b11;
    s_araddr = a; s_arvalid = 1;
    while (!hs && cyc < 40) begin
      @(negedge clk);
      hs = s_arready;
      @(posedge clk); #1;
      cyc++;
    end
    s_arvalid = 0;
    chk("rd_addr_accepted", hs, 1);
    s_rready = 1;
    cyc = 0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      if (s_rvalid) begin
        got = 1; data = s_rdata; resp = s_rresp;
      end
      @(posedge clk); #1;
      cyc++;
    end
    s_rready = 0;
    chk("rd_data_seen", got, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0] resp;
    logic [31:0] rd;
    int lat, hi;
    logic aw_seen;
    int addrs[12] = '{'h000, 'h004, 'h008, 'h00C, 'h010, 'h100, 'h104, 'h108,
                      'h014, 'h20C, 'h0FC, 'h10C};

    repeat (3) @(posedge clk);
    #1;
    chk_en = 1;
    reset = 0;
    @(negedge clk); chk("awready_first_cycle_after_reset", s_awready, 0);
    @(posedge clk); #1;
    @(negedge clk); chk("awready_second_cycle_after_reset", s_awready, 1);
    chk("arready_second_cycle_after_reset", s_arready, 1);
    @(posedge clk); #1;

    // same-cycle AW/W, minimum latency and readback
    axi_write(12'h000, 32'h0280_002F, 4'hF, 0, 0, 0, resp, lat, hi, aw_seen);
    chk("w000_bresp", resp, 0);
    chk("w000_latency", lat, 1);
    axi_read(12'h000, rd, resp);
    chk("r000_data", rd, 32'h0280_002F);
    chk("r000_resp", resp, 0);
    axi_write(12'h004, 32'h031F_0060, 4'hF, 0, 0, 0, resp, lat, hi, aw_seen);
    axi_read(12'h004, rd, resp);
    chk("r004_data", rd, 32'h031F_0060);
    chk("active_width_still_zero", horiz_display_width, 0);

    // W three cycles before AW, B held off for four cycles
    axi_write(12'h104, 32'h0000_0050, 4'hF, 3, 0, 4, resp, lat, hi, aw_seen);
    chk("w104_bresp", resp, 0);
    chk("w104_bvalid_held_cycles", hi, 5);
    chk("w104_no_aw_during_bvalid", aw_seen, 0);
    axi_read(12'h104, rd, resp);
    chk("r104_pitch_shadow", rd, 80);
    chk("pitch_active_still_zero", pitch, 0);

    // 640x480 with display off: CTRL loads active immediately
    axi_write(12'h008, 32'h01E0_0020, 4'hF, 1, 0, 0, resp, lat, hi, aw_seen);
    axi_write(12'h00C, 32'h020C_0002, 4'hF, 0, 2, 1, resp, lat, hi, aw_seen);
    axi_write(12'h108, 32'h1, 4'hF, 0, 0, 0, resp, lat, hi, aw_seen);
    chk("ctrl_h_width", horiz_display_width, 640);
    chk("ctrl_h_start", horiz_display_start, 47);
    chk("ctrl_h_sync", horiz_sync_width, 96);
    chk("ctrl_h_total", horiz_total_width, 799);
    chk("ctrl_v_width", vert_display_width, 480);
    chk("ctrl_v_total", vert_total_width, 524);
    chk("ctrl_display_en", display_en, 1);
    chk("ctrl_not_pending", update_pending, 0);

    // display on: update waits for frame_end
    axi_write(12'h000, 32'h0320_0057, 4'hF, 0, 0, 0, resp, lat, hi, aw_seen);
    axi_write(12'h108, 32'h1, 4'hF, 0, 0, 0, resp, lat, hi, aw_seen);
    chk("pend_update_pending", update_pending, 1);
    chk("pend_width_held", horiz_display_width, 640);
    axi_read(12'h108, rd, resp);
    chk("pend_ctrl_read", rd, 32'h3);
    @(negedge clk); fe_manual = 1;
    @(posedge clk); #2; fe_manual = 0;
    @(negedge clk); chk("frame_cycle_width_old", horiz_display_width, 640);
    @(posedge clk); #2;
    @(negedge clk);
    chk("after_frame_width", horiz_display_width, 800);
    chk("after_frame_start", horiz_display_start, 87);
    chk("after_frame_not_pending", update_pending, 0);
    @(posedge clk); #1;
    axi_read(12'h108, rd, resp);
    chk("after_frame_ctrl_read", rd, 32'h1);

    // unmapped accesses
    axi_read(12'h014, rd, resp);
    chk("r014_resp", resp, 2'b10);
    chk("r014_data", rd, 0);
    axi_write(12'h20C, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, resp, lat, hi, aw_seen);
    chk("w20c_resp", resp, 2'b10);
    axi_read(12'h000, rd, resp);
    chk("r000_unchanged", rd, 32'h0320_0057);

    // randomized traffic with random frame_end pulses
    fe_rand = 1;
    for (int t = 0; t < 250; t++) begin
      logic [11:0] a;
      logic [31:0] d;
      logic [3:0] st;
      a = 12'(addrs[$urandom_range(0, 11)]) | 12'($urandom_range(0, 3));
      if ($urandom_range(0, 9) < 6) begin
        d = $urandom;
        if ((a & 12'hFFC) == 12'h108) d[0] = ($urandom_range(0, 3) != 0);
        st = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
        axi_write(a, d, st, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                  resp, lat, hi, aw_seen);
      end else begin
        axi_read(a, rd, resp);
      end
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    fe_rand = 0;
    repeat (2) @(posedge clk);
    #1;

    // reset while an AW beat is held: transaction is dropped
    s_awaddr = 12'h100; s_awvalid = 1;
    @(negedge clk); chk("rst_test_aw_accepted", s_awready, 1);
    @(posedge clk); #1;
    s_awvalid = 0;
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_no_bvalid", s_bvalid, 0);
      chk("rst_display_off", display_en, 0);
      chk("rst_fb_base_zero", fb_base, 0);
      @(posedge clk); #1;
    end
    s_wdata = 32'hDEAD_BEEF; s_wstrb = 4'hF; s_wvalid = 1;
    @(posedge clk); #1;
    s_wvalid = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_w_alone_no_bvalid", s_bvalid, 0);
      @(posedge clk); #1;
    end

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
